aes_dec_round_ctrl: RTL and testbench

- Sequencer for the AES-128 inverse cipher.
- Owns the 128-bit state register and runs the four stage units (AddRoundKey, InvShiftRows, InvSubBytes, InvMixColumns) one at a time, using one-hot start/done handshakes.
- Supplies the round-key index to the key store.
- Presents a valid/ready stream interface on the ciphertext input and the plaintext output.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_stage_handshake.sv | 54 +++++
 rtl/aes_dec_round_ctrl.sv | 143 ++++++++++++++
 tb/tb_aes_dec_round_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared state encoding, stage one-hot codes and sizes for the AES-128 decrypt sequencer
package aes_pkg;

   localparam int AES_NR = 10;
   localparam int BLK_W  = 128;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADD,
      ST_SHIFT,
      ST_SUB,
      ST_MIX,
      ST_DONE
   } aes_state_e;

   localparam logic [3:0] STG_ADD   = 4'b0001;
   localparam logic [3:0] STG_SUB   = 4'b0010;
   localparam logic [3:0] STG_SHIFT = 4'b0100;
   localparam logic [3:0] STG_MIX   = 4'b1000;

   // Stage unit owned by a controller state; zero for IDLE and DONE.
   function automatic logic [3:0] stage_of(input aes_state_e s);
      case (s)
         ST_ADD:   return STG_ADD;
         ST_SHIFT: return STG_SHIFT;
         ST_SUB:   return STG_SUB;
         ST_MIX:   return STG_MIX;
         default:  return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/aes_stage_handshake.sv
// rtl/aes_stage_handshake.sv - start-pulse generator and done matcher for the stage units
// Stage timeout counter present only when AES_DEC_TIMEOUT_EN is defined.
module aes_stage_handshake
   import aes_pkg::*;
`ifdef AES_DEC_TIMEOUT_EN
#(
   parameter int TIMEOUT = 64
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] stage_sel,
   input  logic [3:0] stage_done,
   output logic [3:0] stage_start,
`ifdef AES_DEC_TIMEOUT_EN
   output logic       timeout,
`endif
   output logic       done_hit
);

   logic [3:0] sel_q, sel_d;

   // Consecutive states never share a stage unit, so a change in selection marks state entry.
   always_comb begin
      sel_d       = stage_sel;
      stage_start = stage_sel & ~sel_q;
      done_hit    = |(stage_sel & stage_done);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sel_q <= '0;
      else        sel_q <= sel_d;
   end

`ifdef AES_DEC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d, cnt_cur;

   // cnt_cur counts cycles already spent waiting; the start cycle is cycle zero.
   always_comb begin
      cnt_cur = (|stage_start) ? '0 : cnt_q;
      cnt_d   = (|stage_sel) ? cnt_cur + CW'(1) : '0;
      timeout = (|stage_sel) && !done_hit && (cnt_cur == CW'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`endif

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// rtl/aes_dec_round_ctrl.sv - AES-128 inverse-cipher sequencer owning the state register
// Optional stage timeout and sticky err enabled by AES_DEC_TIMEOUT_EN.
module aes_dec_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
`ifdef AES_DEC_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 64
`endif
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] cipher_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] plain_out,
   output logic [3:0]       stage_start,
   output logic [BLK_W-1:0] stage_text,
   output logic [3:0]       key_idx,
   input  logic [3:0]       stage_done,
   input  logic [BLK_W-1:0] mix_text,
   input  logic [BLK_W-1:0] shift_text,
   input  logic [BLK_W-1:0] sub_text,
   input  logic [BLK_W-1:0] add_text,
   output logic             busy,
   output logic             err
);

   aes_state_e       state_q, state_d;
   logic [3:0]       round_q, round_d;
   logic [BLK_W-1:0] text_q, text_d;
   logic             done_hit;

`ifdef AES_DEC_TIMEOUT_EN
   logic timeout;
   logic err_q, err_d;

   aes_stage_handshake #(
      .TIMEOUT (TIMEOUT)
   ) u_hs (
      .clk         (clk),
      .rst_n       (rst_n),
      .stage_sel   (stage_of(state_q)),
      .stage_done  (stage_done),
      .stage_start (stage_start),
      .timeout     (timeout),
      .done_hit    (done_hit)
   );
`else
   aes_stage_handshake u_hs (
      .clk         (clk),
      .rst_n       (rst_n),
      .stage_sel   (stage_of(state_q)),
      .stage_done  (stage_done),
      .stage_start (stage_start),
      .done_hit    (done_hit)
   );
`endif

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      text_d  = text_q;
      case (state_q)
         ST_IDLE: if (in_valid && in_ready) begin
            text_d  = cipher_in;
            round_d = 4'(NR);
            state_d = ST_ADD;
         end
         ST_ADD: if (done_hit) begin
            text_d = add_text;
            if (round_q == 4'(NR)) begin
               round_d = round_q - 4'd1;
               state_d = ST_SHIFT;
            end else if (round_q == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_MIX;
            end
         end
         ST_SHIFT: if (done_hit) begin
            text_d  = shift_text;
            state_d = ST_SUB;
         end
         ST_SUB: if (done_hit) begin
            text_d  = sub_text;
            state_d = ST_ADD;
         end
         ST_MIX: if (done_hit) begin
            text_d  = mix_text;
            round_d = round_q - 4'd1;
            state_d = ST_SHIFT;
         end
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
`ifdef AES_DEC_TIMEOUT_EN
      // A stalled stage abandons the block; nothing is presented downstream.
      if (timeout) state_d = ST_IDLE;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         text_q  <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         text_q  <= text_d;
      end
   end

`ifdef AES_DEC_TIMEOUT_EN
   always_comb begin
      err_d = err_q;
      if (timeout)                                           err_d = 1'b1;
      else if (state_q == ST_IDLE && in_valid && in_ready)   err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign in_ready   = (state_q == ST_IDLE) && rst_n;
   assign out_valid  = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign plain_out  = text_q;
   assign stage_text = text_q;
   assign key_idx    = (state_q == ST_ADD) ? round_q : 4'd0;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb/tb_aes_dec_round_ctrl.sv - scoreboard bench for aes_dec_round_ctrl with behavioural AES stage units
module tb_aes_dec_round_ctrl;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid, in_ready, out_valid, out_ready, busy, err;
   logic [127:0] cipher_in, plain_out, stage_text;
   logic [127:0] mix_text, shift_text, sub_text, add_text;
   logic [3:0]   stage_start, stage_done, key_idx;

   always #5 clk = ~clk;

   aes_dec_round_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .cipher_in(cipher_in),
      .out_valid(out_valid), .out_ready(out_ready), .plain_out(plain_out),
      .stage_start(stage_start), .stage_text(stage_text), .key_idx(key_idx),
      .stage_done(stage_done),
      .mix_text(mix_text), .shift_text(shift_text), .sub_text(sub_text), .add_text(add_text),
      .busy(busy), .err(err)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // AES reference arithmetic
   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk    [11];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = 8'h00; aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] a, input int n);
      logic [15:0] t;
      t = {a, a} >> (8 - n);
      return t[7:0];
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] x, input int i);
      return x[127-8*i -: 8];
   endfunction

   task automatic init_tables();
      logic [7:0]   inv, s, rc;
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [127:0] key;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
      key = 128'h000102030405060708090a0b0c0d0e0f;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]] ^ rc, sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] f_shift(input logic [127:0] x, input bit inv);
      logic [127:0] y;
      y = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (inv) y[127-8*(r+4*((c+r)%4)) -: 8] = gb(x, r + 4*c);
            else     y[127-8*(r+4*c) -: 8]         = gb(x, r + 4*((c+r)%4));
         end
      return y;
   endfunction

   function automatic logic [127:0] f_sub(input logic [127:0] x, input bit inv);
      logic [127:0] y;
      for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv ? isbox[gb(x, i)] : sbox[gb(x, i)];
      return y;
   endfunction

   function automatic logic [127:0] f_mix(input logic [127:0] x, input bit inv);
      logic [7:0]   m [4];
      logic [7:0]   acc;
      logic [127:0] y;
      if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
      else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
      y = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gm(gb(x, 4*c + j), m[(j - r + 4) % 4]);
            y[127-8*(4*c+r) -: 8] = acc;
         end
      return y;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ rk[0];
      for (int r = 1; r < 10; r++) s = f_mix(f_shift(f_sub(s, 0), 0), 0) ^ rk[r];
      return f_shift(f_sub(s, 0), 0) ^ rk[10];
   endfunction

   // Behavioural stage units: done arrives lat cycles after start; idle units drive junk.
   logic [3:0]   done_m = '0, spur = '0, hold = '0, pend = '0;
   int           lat = 2, wcnt = 0;
   logic [127:0] res = '0, spur_text = '0;

   assign stage_done = done_m | spur;
   assign add_text   = done_m[0] ? res : {32{4'hA}};
   assign sub_text   = done_m[1] ? res : {32{4'hB}};
   assign shift_text = done_m[2] ? res : {32{4'hC}};
   assign mix_text   = spur[3] ? spur_text : (done_m[3] ? res : {32{4'hD}});

   always @(negedge clk) begin
      done_m = '0;
      if (!rst_n) begin
         pend = '0;
      end else begin
         if ((|stage_start) && !(|(stage_start & hold))) begin
            pend = stage_start;
            wcnt = lat;
            case (stage_start)
               STG_ADD:   res = stage_text ^ rk[key_idx];
               STG_SHIFT: res = f_shift(stage_text, 1);
               STG_SUB:   res = f_sub(stage_text, 1);
               default:   res = f_mix(stage_text, 1);
            endcase
         end
         if (|pend) begin
            if (wcnt == 0) begin
               done_m = pend;
               pend   = '0;
            end else begin
               wcnt--;
            end
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and start-sequence monitors
   logic [127:0] sb [$];
   logic [7:0]   slog [$];
   int           onehot_bad = 0;

   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         if (!$onehot0(stage_start)) onehot_bad++;
         if (|stage_start) slog.push_back({stage_start, key_idx});
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_unexpected_out", out_valid, 1'b0);
            else                check("plain", plain_out, sb.pop_front());
         end
      end
   end

   task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
      int n;
      n = 0;
      in_valid  = 1'b1;
      cipher_in = ct;
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      acc = cyc;
      if (in_ready) sb.push_back(pt);
      else          check("accept_timeout", in_ready, 1'b1);
      @(negedge clk);
      in_valid  = 1'b0;
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_out(output int c);
      int n;
      n = 0;
      while (!out_valid && n < 3000) begin @(negedge clk); n++; end
      if (!out_valid) check("out_timeout", out_valid, 1'b1);
      c = cyc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int           acc, t, n, ns, sbad, rbad;
      logic [127:0] pt, snap;
      logic [7:0]   es [$];

      in_valid = 1'b0; cipher_in = '0; out_ready = 1'b1;
      init_tables();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_start", stage_start, 4'b0);
      check("rst_plain", plain_out, 128'b0);
      check("rst_key_idx", key_idx, 4'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b1);

      // FIPS-197 C.1 with order and latency
      slog.delete();
      send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, acc);
      wait_out(t);
      check("c1_latency", t - acc, 121);
      @(negedge clk);
      es.push_back({STG_ADD, 4'd10});
      for (int r = 9; r >= 1; r--) begin
         es.push_back({STG_SHIFT, 4'd0}); es.push_back({STG_SUB, 4'd0});
         es.push_back({STG_ADD, 4'(r)});  es.push_back({STG_MIX, 4'd0});
      end
      es.push_back({STG_SHIFT, 4'd0}); es.push_back({STG_SUB, 4'd0}); es.push_back({STG_ADD, 4'd0});
      check("seq_len", slog.size(), 40);
      for (int i = 0; i < es.size() && i < slog.size(); i++) begin
         if (es[i][7:4] == STG_ADD) check($sformatf("seq%0d", i), slog[i], es[i]);
         else                       check($sformatf("seq%0d", i), slog[i][7:4], es[i][7:4]);
      end

      // Backpressure in DONE
      out_ready = 1'b0;
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(encrypt(pt), pt, acc);
      wait_out(t);
      snap = plain_out; sbad = 0; rbad = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid  = (i % 2 == 0);
         cipher_in = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (plain_out !== snap) sbad++;
         if (in_ready) rbad++;
      end
      in_valid = 1'b0;
      check("bp_plain_stable", sbad, 0);
      check("bp_in_ready_low", rbad, 0);
      check("bp_out_valid_held", out_valid, 1'b1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", in_ready, 1'b1);
      check("bp_release_busy", busy, 1'b0);

      // Spurious mix done while waiting in SUB
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(encrypt(pt), pt, acc);
      n = 0;
      while (stage_start !== STG_SUB && n < 500) begin @(negedge clk); n++; end
      check("spur_sub_start", stage_start, STG_SUB);
      snap = stage_text; spur_text = ~stage_text; spur = 4'b1000;
      @(negedge clk);
      spur = 4'b0000;
      check("spur_text_hold", stage_text, snap);
      check("spur_no_advance", stage_start, 4'b0);
      check("spur_busy", busy, 1'b1);
      wait_out(t);
      check("spur_latency", t - acc, 121);
      @(negedge clk);

      // Reset during round-5 MIX (21st stage start)
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(encrypt(pt), pt, acc);
      ns = 0; n = 0;
      while (n < 2000) begin
         if (|stage_start) begin
            ns++;
            if (ns == 21) break;
         end
         @(negedge clk); n++;
      end
      check("rst_mid_mix", stage_start, STG_MIX);
      #3 rst_n = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1'b0);
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_start", stage_start, 4'b0);
      check("arst_plain", plain_out, 128'b0);
      check("arst_text", stage_text, 128'b0);
      check("arst_key_idx", key_idx, 4'b0);
      check("arst_err", err, 1'b0);
      if (sb.size() > 0) void'(sb.pop_back());
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1'b1);
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(encrypt(pt), pt, acc);
      wait_out(t);
      check("post_rst_latency", t - acc, 121);
      @(negedge clk);

      // Stage latency extremes, including done in the start cycle
      for (int k = 0; k < 3; k++) begin
         lat = (k == 0) ? 0 : ((k == 1) ? 1 : 3);
         pt = {$urandom, $urandom, $urandom, $urandom};
         send(encrypt(pt), pt, acc);
         wait_out(t);
         check($sformatf("latency_L%0d", lat), t - acc, 1 + 40 * (lat + 1));
         @(negedge clk);
      end
      lat = 2;

`ifdef AES_DEC_TIMEOUT_EN
      hold = STG_SHIFT;
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(encrypt(pt), pt, acc);
      n = 0;
      while (stage_start !== STG_SHIFT && n < 100) begin @(negedge clk); n++; end
      check("to_shift_start", stage_start, STG_SHIFT);
      t = cyc; n = 0;
      while (!err && n < 300) begin @(negedge clk); n++; end
      check("to_err", err, 1'b1);
      check("to_cycles", cyc - t, 64);
      check("to_idle", in_ready, 1'b1);
      check("to_no_out", out_valid, 1'b0);
      if (sb.size() > 0) void'(sb.pop_back());
      hold = '0;
      @(negedge clk);
      check("to_err_sticky", err, 1'b1);
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(encrypt(pt), pt, acc);
      check("to_err_cleared", err, 1'b0);
      wait_out(t);
      check("to_next_latency", t - acc, 121);
      @(negedge clk);
`endif

      @(negedge clk);
      check("onehot_starts", onehot_bad, 0);
      check("sb_drained", sb.size(), 0);
`ifndef AES_DEC_TIMEOUT_EN
      check("err_tied_low", err, 1'b0);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
